munoc_tid_response_tracker: RTL and testbench

//  Response-side TID ordering tracker for the MUNOC slave interface.
//  - Records the TID of every accepted request in a circular TID queue.
//  - Checks each returning response against the oldest outstanding TID.
//  - Emits a registered response-done pulse for the request-side issue gate.
//  - Single clock domain; sits between the NI request decoder and the response packetizer.

---
 rtl/munoc_tid_response_tracker.sv | 109 ++++++++++
 tb/tb_munoc_tid_response_tracker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/munoc_tid_response_tracker.sv
// Response-side TID ordering tracker: circular TID queue, head-TID checking, done pulse.
// Optional MUNOC_TID_TRACKER_ERR_CAPTURE_EN adds err_got_tid/err_exp_tid capture registers.
module munoc_tid_response_tracker #(
  parameter int BW_TID        = 4,
  parameter int DEPTH         = 8,
  parameter int SAME_TID_ONLY = 1,
  localparam int BW_COUNT     = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [BW_TID-1:0]   req_tid,
  output logic                req_ready,
  input  logic                resp_valid,
  input  logic                resp_ready,
  input  logic                resp_last,
  input  logic [BW_TID-1:0]   resp_tid,
  output logic [BW_TID-1:0]   expected_tid,
  output logic [BW_COUNT-1:0] outstanding_count,
  output logic                resp_done,
  output logic                err_unexpected,
  output logic                err_mismatch,
  input  logic                err_clear
`ifdef MUNOC_TID_TRACKER_ERR_CAPTURE_EN
  ,
  output logic [BW_TID-1:0]   err_got_tid,
  output logic [BW_TID-1:0]   err_exp_tid
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]    PTR_ONE   = PTR_W'(1);
  localparam logic [BW_COUNT-1:0] CNT_ONE   = BW_COUNT'(1);
  localparam logic [BW_COUNT-1:0] CNT_DEPTH = BW_COUNT'(DEPTH);

  logic [BW_TID-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [BW_COUNT-1:0] count;

  logic              empty;
  logic              full;
  logic [BW_TID-1:0] head_tid;
  logic [BW_TID-1:0] newest_tid;
  logic              push;
  logic              resp_fire;
  logic              pop;
  logic              set_mismatch;
  logic              set_unexpected;

  assign empty      = (count == '0);
  assign full       = (count == CNT_DEPTH);
  assign head_tid   = mem[rd_ptr];
  assign newest_tid = mem[wr_ptr - PTR_ONE];

  assign req_ready  = ~full & (empty | (SAME_TID_ONLY == 0) | (req_tid == newest_tid));
  assign push       = req_valid & req_ready;
  assign resp_fire  = resp_valid & resp_ready & resp_last;
  assign pop        = resp_fire & ~empty;

  assign set_mismatch   = pop & (resp_tid != head_tid);
  assign set_unexpected = resp_fire & empty;

  assign expected_tid      = empty ? '0 : head_tid;
  assign outstanding_count = count;

  // Storage is not reset; empty gates every read that could expose stale entries.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_tid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      resp_done      <= 1'b0;
      err_unexpected <= 1'b0;
      err_mismatch   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
      resp_done <= pop;
      if (err_clear) begin
        err_unexpected <= 1'b0;
        err_mismatch   <= 1'b0;
      end else begin
        if (set_unexpected) err_unexpected <= 1'b1;
        if (set_mismatch)   err_mismatch   <= 1'b1;
      end
    end
  end

`ifdef MUNOC_TID_TRACKER_ERR_CAPTURE_EN
  // Only the first mismatch since the last clear is captured.
  always_ff @(posedge clk) begin
    if (rst || err_clear) begin
      err_got_tid <= '0;
      err_exp_tid <= '0;
    end else if (set_mismatch && !err_mismatch) begin
      err_got_tid <= resp_tid;
      err_exp_tid <= head_tid;
    end
  end
`endif

endmodule

// File: tb/tb_munoc_tid_response_tracker.sv
// Randomized + directed bench for munoc_tid_response_tracker against a queue-based model.
module tb_munoc_tid_response_tracker;

  localparam int DEPTH = 8;
  localparam int SAME  = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [3:0] req_tid = '0;
  logic       req_ready;
  logic       resp_valid = 1'b0;
  logic       resp_ready = 1'b0;
  logic       resp_last = 1'b0;
  logic [3:0] resp_tid = '0;
  logic [3:0] expected_tid;
  logic [3:0] outstanding_count;
  logic       resp_done;
  logic       err_unexpected;
  logic       err_mismatch;
  logic       err_clear = 1'b0;
`ifdef MUNOC_TID_TRACKER_ERR_CAPTURE_EN
  logic [3:0] err_got_tid;
  logic [3:0] err_exp_tid;
`endif

  munoc_tid_response_tracker #(.BW_TID(4), .DEPTH(DEPTH), .SAME_TID_ONLY(SAME)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_tid(req_tid), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_last(resp_last),
    .resp_tid(resp_tid), .expected_tid(expected_tid),
    .outstanding_count(outstanding_count), .resp_done(resp_done),
    .err_unexpected(err_unexpected), .err_mismatch(err_mismatch),
    .err_clear(err_clear)
`ifdef MUNOC_TID_TRACKER_ERR_CAPTURE_EN
    , .err_got_tid(err_got_tid), .err_exp_tid(err_exp_tid)
`endif
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int done_seen = 0;

  // reference model: outstanding TIDs in issue order
  logic [3:0] m_q[$];
  logic       m_done, m_unexp, m_mism;
  logic [3:0] m_got, m_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_ready();
    if (m_q.size() >= DEPTH) return 1'b0;
    if (m_q.size() == 0 || SAME == 0) return 1'b1;
    return req_tid == m_q[m_q.size()-1];
  endfunction

  task automatic model_step();
    logic push, fire, pop, mism, unexp;
    if (rst) begin
      m_q.delete();
      m_done = 0; m_unexp = 0; m_mism = 0; m_got = 0; m_exp = 0;
      return;
    end
    push  = req_valid && m_ready();
    fire  = resp_valid && resp_ready && resp_last;
    pop   = fire && (m_q.size() > 0);
    unexp = fire && (m_q.size() == 0);
    mism  = pop && (resp_tid != m_q[0]);
    if (err_clear) begin
      m_got = 0; m_exp = 0;
    end else if (mism && !m_mism) begin
      m_got = resp_tid; m_exp = m_q[0];
    end
    if (err_clear) begin
      m_unexp = 0; m_mism = 0;
    end else begin
      m_unexp = m_unexp | unexp;
      m_mism  = m_mism | mism;
    end
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(req_tid);
    m_done = pop;
  endtask

  task automatic check_state();
    chk("count", 32'(outstanding_count), 32'(m_q.size()));
    chk("expected_tid", 32'(expected_tid), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    chk("resp_done", 32'(resp_done), 32'(m_done));
    chk("err_unexpected", 32'(err_unexpected), 32'(m_unexp));
    chk("err_mismatch", 32'(err_mismatch), 32'(m_mism));
`ifdef MUNOC_TID_TRACKER_ERR_CAPTURE_EN
    chk("err_got_tid", 32'(err_got_tid), 32'(m_got));
    chk("err_exp_tid", 32'(err_exp_tid), 32'(m_exp));
`endif
    if (resp_done) done_seen++;
  endtask

  task automatic cyc(input logic rv, input logic [3:0] rt, input logic pv, input logic pr,
                     input logic pl, input logic [3:0] pt, input logic clr, input logic r);
    req_valid = rv; req_tid = rt; resp_valid = pv; resp_ready = pr;
    resp_last = pl; resp_tid = pt; err_clear = clr; rst = r;
    #1;
    if (!r) chk("req_ready", 32'(req_ready), 32'(m_ready()));
    @(posedge clk);
    model_step();
    #1;
    check_state();
  endtask

  task automatic push_t(input logic [3:0] t);
    cyc(1, t, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pop_t(input logic [3:0] t);
    cyc(0, 0, 1, 1, 1, t, 0, 0);
  endtask

  initial begin
    #2;
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("reset_count", 32'(outstanding_count), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_ready", 32'(req_ready), 32'd1);

    // 1: three same-TID pushes, a non-last beat, then three completions
    for (int i = 0; i < 3; i++) push_t(4'd3);
    chk("s1_count", 32'(outstanding_count), 32'd3);
    chk("s1_exp", 32'(expected_tid), 32'd3);
    cyc(0, 0, 1, 1, 0, 3, 0, 0);
    chk("s1_nonlast", 32'(outstanding_count), 32'd3);
    done_seen = 0;
    for (int i = 0; i < 3; i++) pop_t(4'd3);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("s1_dones", 32'(done_seen), 32'd3);
    chk("s1_empty", 32'(outstanding_count), 32'd0);

    // 2: different TID blocked until queue drains
    push_t(4'd2);
    cyc(1, 5, 0, 0, 0, 0, 0, 0);
    chk("s2_blocked", 32'(outstanding_count), 32'd1);
    cyc(1, 5, 1, 1, 1, 2, 0, 0);
    cyc(1, 5, 0, 0, 0, 0, 0, 0);
    chk("s2_accept", 32'(expected_tid), 32'd5);
    pop_t(4'd5);

    // 3: full queue, simultaneous offer and completion: only the pop happens
    for (int i = 0; i < DEPTH; i++) push_t(4'd1);
    chk("s3_full", 32'(outstanding_count), 32'(DEPTH));
    cyc(1, 1, 1, 1, 1, 1, 0, 0);
    chk("s3_pop_only", 32'(outstanding_count), 32'(DEPTH-1));
    while (m_q.size() > 0) pop_t(4'd1);

    // count==1 push & pop together
    push_t(4'd9);
    cyc(1, 9, 1, 1, 1, 9, 0, 0);
    chk("s3_cnt1", 32'(outstanding_count), 32'd1);
    pop_t(4'd9);

    // 4: unexpected response, clear, and clear-over-set priority
    pop_t(4'd4);
    chk("s4_unexp", 32'(err_unexpected), 32'd1);
    chk("s4_done", 32'(resp_done), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    chk("s4_clear", 32'(err_unexpected), 32'd0);
    cyc(0, 0, 1, 1, 1, 4, 1, 0);
    chk("s4_prio", 32'(err_unexpected), 32'd0);

    // 5: mismatch still pops; a second mismatch must not overwrite capture
    push_t(4'd6);
    push_t(4'd6);
    pop_t(4'd7);
    chk("s5_mism", 32'(err_mismatch), 32'd1);
    chk("s5_popped", 32'(outstanding_count), 32'd1);
    pop_t(4'd8);
`ifdef MUNOC_TID_TRACKER_ERR_CAPTURE_EN
    chk("s5_got", 32'(err_got_tid), 32'd7);
    chk("s5_exp", 32'(err_exp_tid), 32'd6);
`endif
    cyc(0, 0, 0, 0, 0, 0, 1, 0);

    // 6: alternating push/pop across pointer wrap
    for (int i = 0; i < 12; i++) begin
      push_t(4'(i));
      pop_t(4'(i));
    end
    chk("s6_noerr", 32'({err_unexpected, err_mismatch}), 32'd0);

    // random phase
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] rt, pt;
      rt = 4'($urandom_range(0, 2));
      if (m_q.size() > 0 && $urandom_range(0, 9) < 8) pt = m_q[0];
      else pt = 4'($urandom_range(0, 15));
      cyc(1'($urandom_range(0, 1)), rt,
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 2) != 0), pt,
          1'($urandom_range(0, 30) == 0), 1'($urandom_range(0, 400) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
